// File: rtl/arm_dp_sequencer.sv
// arm_dp_sequencer: four-state sequencer (IDLE, READ, EXEC, WRITE) for ARM-style
// data-processing instructions. It owns sixteen 32-bit registers and the NZCV
// flags, and it drives an external ALU during the EXEC cycle.
// Optional build macro DPSEQ_DBG_PORT_EN adds the dbg_addr/dbg_data
// combinational register read port.
module arm_dp_sequencer (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic        in_s,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [31:0] in_op2,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  input  logic [31:0] alu_out,
  input  logic        alu_nf,
  input  logic        alu_cf,
  input  logic        alu_zf,
  input  logic        alu_vf,
  output logic [3:0]  flags,
  output logic        done
`ifdef DPSEQ_DBG_PORT_EN
  ,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_e;

  state_e      state, state_nxt;

  // Instruction fields captured on acceptance
  logic [3:0]  op_q;
  logic        s_q;
  logic [3:0]  rn_q;
  logic [3:0]  rd_q;
  logic [31:0] op2_q;

  // Operand A (read in READ) and ALU results (latched at the end of EXEC)
  logic [31:0] opa_q;
  logic [31:0] res_q;
  logic [3:0]  aflags_q;   // {N,Z,C,V}

  logic [31:0] regs [16];

  // CMP, CMN, TST and TEQ share the 01xx encoding. They only set flags.
  logic        is_cmp;
  assign is_cmp = (op_q[3:2] == 2'b01);

  // State register; reset aborts any instruction in flight
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and per-state outputs. The outputs are decoded from the
  // state only, so an asynchronous reset clears them immediately.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_nxt = state;
    in_ready  = 1'b0;
    done      = 1'b0;
    alu_op    = 4'd0;
    alu_a     = 32'd0;
    alu_b     = 32'd0;
    alu_cin   = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = READ;
      end
      READ: state_nxt = EXEC;
      EXEC: begin
        alu_op    = op_q;
        alu_a     = opa_q;
        alu_b     = op2_q;
        alu_cin   = flags[1];
        state_nxt = WRITE;
      end
      WRITE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the instruction, operand A and the ALU results in their stages
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      op_q     <= 4'd0;
      s_q      <= 1'b0;
      rn_q     <= 4'd0;
      rd_q     <= 4'd0;
      op2_q    <= 32'd0;
      opa_q    <= 32'd0;
      res_q    <= 32'd0;
      aflags_q <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register sees the values from before the clock edge.
      if (state == IDLE && in_valid) begin
        op_q  <= in_op;
        s_q   <= in_s;
        rn_q  <= in_rn;
        rd_q  <= in_rd;
        op2_q <= in_op2;
      end
      if (state == READ) opa_q <= regs[rn_q];
      if (state == EXEC) begin
        res_q    <= alu_out;
        aflags_q <= {alu_nf, alu_zf, alu_cf, alu_vf};
      end
    end
  end

  // Register file and flags write-back in WRITE
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      // NOTE: this register array must read as zero after reset, so it is
      // reset explicitly. It is therefore built from flops, not inferred RAM.
      for (int i = 0; i < 16; i++) regs[i] <= 32'd0;
      flags <= 4'd0;
    end else if (state == WRITE) begin
      if (!is_cmp)        regs[rd_q] <= res_q;
      if (s_q || is_cmp)  flags      <= aflags_q;
    end
  end

`ifdef DPSEQ_DBG_PORT_EN
  // Debug read port: combinational view of any register
  always_comb begin
    dbg_data = regs[dbg_addr];
  end
`endif

endmodule

// File: tb/tb_arm_dp_sequencer.sv
// Testbench for arm_dp_sequencer. Register contents are observed on alu_a when
// a later instruction reads them. A plain array model tracks the expected
// register and flag state.
module tb_arm_dp_sequencer;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = 4'd0;
  logic        in_s = 1'b0;
  logic [3:0]  in_rn = 4'd0;
  logic [3:0]  in_rd = 4'd0;
  logic [31:0] in_op2 = 32'd0;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_cin;
  logic [31:0] alu_out = 32'd0;
  logic        alu_nf = 1'b0;
  logic        alu_cf = 1'b0;
  logic        alu_zf = 1'b0;
  logic        alu_vf = 1'b0;
  logic [3:0]  flags;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: architectural registers and flags {N,Z,C,V}
  logic [31:0] m_r [16];
  logic [3:0]  m_f;

  arm_dp_sequencer dut (
    .CLK(CLK), .CLR(CLR),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_s(in_s), .in_rn(in_rn), .in_rd(in_rd), .in_op2(in_op2),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_out(alu_out), .alu_nf(alu_nf), .alu_cf(alu_cf), .alu_zf(alu_zf),
    .alu_vf(alu_vf), .flags(flags), .done(done)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = 32'd0;
    m_f = 4'd0;
  endtask

  task automatic check_alu_idle(input string tag);
    check({tag, "_alu_op"},  {28'd0, alu_op}, 32'd0);
    check({tag, "_alu_a"},   alu_a,           32'd0);
    check({tag, "_alu_b"},   alu_b,           32'd0);
    check({tag, "_alu_cin"}, {31'd0, alu_cin}, 32'd0);
  endtask

  // Issue one instruction from an IDLE negedge and check every cycle through
  // to the next IDLE. The ALU returns res/af ({N,Z,C,V}). If hold is set,
  // in_valid stays high with garbage fields while the instruction runs, and
  // it is still high when the task returns.
  task automatic run_instr(input logic [3:0] op, input logic s, input logic [3:0] rn,
                           input logic [3:0] rd, input logic [31:0] op2,
                           input logic [31:0] res, input logic [3:0] af, input bit hold);
    bit cmp_op;
    cmp_op = (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0110) || (op == 4'b0111);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    check("idle_done",  {31'd0, done},     32'd0);
    in_valid = 1'b1; in_op = op; in_s = s; in_rn = rn; in_rd = rd; in_op2 = op2;
    alu_out = res; {alu_nf, alu_zf, alu_cf, alu_vf} = af;
    @(negedge CLK);                          // READ
    in_valid = hold;
    in_op = 4'($urandom); in_s = 1'($urandom); in_rn = 4'($urandom);
    in_rd = 4'($urandom); in_op2 = $urandom;
    check("read_ready", {31'd0, in_ready}, 32'd0);
    check("read_done",  {31'd0, done},     32'd0);
    check_alu_idle("read");
    @(negedge CLK);                          // EXEC
    check("exec_op",  {28'd0, alu_op},  {28'd0, op});
    check("exec_a",   alu_a,            m_r[rn]);
    check("exec_b",   alu_b,            op2);
    check("exec_cin", {31'd0, alu_cin}, {31'd0, m_f[1]});
    check("exec_done", {31'd0, done},   32'd0);
    @(negedge CLK);                          // WRITE
    alu_out = $urandom; {alu_nf, alu_zf, alu_cf, alu_vf} = 4'($urandom);
    check("write_done",  {31'd0, done},     32'd1);
    check("write_ready", {31'd0, in_ready}, 32'd0);
    check("write_flags_old", {28'd0, flags}, {28'd0, m_f});
    check_alu_idle("write");
    if (!cmp_op) m_r[rd] = res;
    if (s || cmp_op) m_f = af;
    @(negedge CLK);                          // back to IDLE
    check("post_flags", {28'd0, flags}, {28'd0, m_f});
    check("post_done",  {31'd0, done},  32'd0);
  endtask

  initial begin
    model_reset();
    // Reset state
    @(negedge CLK);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_done",  {31'd0, done},     32'd0);
    check("rst_flags", {28'd0, flags},    32'd0);
    check_alu_idle("rst");
    CLR = 1'b1;
    @(negedge CLK);

    // MOV R1 <- FFFFFFFF, no flag update although the ALU reports N
    run_instr(4'b1000, 1'b0, 4'd0, 4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1000, 1'b0);
    // AND R2 <- R1 & F0000000 with S: flags N=1
    run_instr(4'b0000, 1'b1, 4'd1, 4'd2, 32'hF000_0000, 32'hF000_0000, 4'b1000, 1'b0);
    // CMP R1, FFFFFFFF: no write to R3, flags Z=1 C=1
    run_instr(4'b0100, 1'b0, 4'd1, 4'd3, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0110, 1'b0);
    // Read back R2 and R3 through operand A (R3 must still be zero)
    run_instr(4'b1010, 1'b0, 4'd2, 4'd4, 32'd1, 32'hF000_0001, 4'b0000, 1'b0);
    run_instr(4'b1010, 1'b0, 4'd3, 4'd5, 32'd1, 32'h0000_0001, 4'b0000, 1'b0);
    // ADC with C=1, then clear C and ADC with C=0
    run_instr(4'b1011, 1'b1, 4'd1, 4'd6, 32'd0, 32'h1234_5678, 4'b0000, 1'b0);
    run_instr(4'b1011, 1'b0, 4'd6, 4'd7, 32'd5, 32'h0000_0009, 4'b1111, 1'b0);
    // rd == rn: the old value is read, the new one is written back
    run_instr(4'b1010, 1'b0, 4'd1, 4'd1, 32'd1, 32'hAAAA_5555, 4'b0000, 1'b0);
    run_instr(4'b1000, 1'b0, 4'd1, 4'd8, 32'd0, 32'd0, 4'b0000, 1'b0);

    // Back-to-back with in_valid held high: one accept and one done per 4 cycles
    for (int k = 0; k < 6; k++)
      run_instr(4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), $urandom,
                $urandom, 4'($urandom), 1'b1);
    in_valid = 1'b0;
    @(negedge CLK);
    check("hold_end_ready", {31'd0, in_ready}, 32'd1);

    // Randomized instruction stream, sometimes with garbage on in_valid mid-flight
    for (int k = 0; k < 40; k++)
      run_instr(4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), $urandom,
                $urandom, 4'($urandom), 1'($urandom));
    in_valid = 1'b0;
    @(negedge CLK);

    // Reset during EXEC: the instruction aborts with no register or flag write
    check("pre_abort_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = 4'b1000; in_s = 1'b1; in_rn = 4'd0; in_rd = 4'd9;
    in_op2 = 32'hDEAD_BEEF; alu_out = 32'hDEAD_BEEF;
    {alu_nf, alu_zf, alu_cf, alu_vf} = 4'b1111;
    @(negedge CLK);                          // READ
    in_valid = 1'b0;
    @(negedge CLK);                          // EXEC
    check("abort_exec_op", {28'd0, alu_op}, 32'h8);
    CLR = 1'b0;
    #1;
    model_reset();
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_done",  {31'd0, done},     32'd0);
    check("abort_flags", {28'd0, flags},    32'd0);
    check_alu_idle("abort");
    @(negedge CLK);
    CLR = 1'b1;
    check("abort_done2",  {31'd0, done},  32'd0);
    check("abort_flags2", {28'd0, flags}, 32'd0);
    @(negedge CLK);
    // R9 (target) and R1 (previously nonzero) must both read back as zero
    run_instr(4'b1000, 1'b0, 4'd9, 4'd10, 32'd0, 32'h0000_0042, 4'b0000, 1'b0);
    run_instr(4'b1000, 1'b0, 4'd1, 4'd11, 32'd0, 32'h0000_0043, 4'b0000, 1'b0);
    run_instr(4'b1000, 1'b0, 4'd10, 4'd12, 32'd0, 32'h0000_0044, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
